mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2, read latency in cycles from issue to valid mem_rdata; legal range 1..7.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; state clears immediately on assertion (reset=0).
REQ-004 if_req  in  1  instruction-fetch request, held with if_addr until if_gnt.
REQ-005 if_addr  in  32  fetch byte address; bits [1:0] ignored.
REQ-006 if_gnt  out  1  one-cycle pulse, fetch issued this cycle.
REQ-007 if_rvalid  out  1  one-cycle pulse, if_rdata valid.
REQ-008 if_rdata  out  32  fetched instruction word.
REQ-009 d_req  in  1  data request, held with d_we/d_addr/d_wdata until d_gnt.
REQ-010 d_we  in  1  1=store, 0=load.
REQ-011 d_addr  in  64  data byte address; bits [2:0] ignored.
REQ-012 d_wdata  in  64  store data.
REQ-013 d_gnt  out  1  one-cycle pulse, data access issued this cycle.
REQ-014 d_done  out  1  one-cycle pulse, load data valid or store complete.
REQ-015 d_rdata  out  64  load data.
REQ-016 mem_en  out  1  memory access strobe, equal to if_gnt|d_gnt.
REQ-017 mem_we  out  1  memory write strobe, 1 only with d_gnt and d_we=1.
REQ-018 mem_addr  out  64  doubleword-aligned address, bits [2:0]=000.
REQ-019 mem_wdata  out  64  equal to d_wdata when d_gnt, else 0.
REQ-020 mem_rdata  in  64  memory read data, valid MEM_LAT cycles after issue.

Function
REQ-021 FSM states: IDLE, WAIT, RESP.
REQ-022 Issue occurs only in IDLE or RESP with at least one req high; gnt, mem_en and mem_addr are combinational in the issue cycle.
REQ-023 Tie-break: with both reqs high, winner is the requester indicated by prio bit; after every grant, prio points to the non-granted requester.
REQ-024 With a single req high, that requester is granted regardless of prio.
REQ-025 Fetch issue: mem_addr={32'b0,if_addr[31:3],3'b000}; registered word select = if_addr[2].
REQ-026 Load or fetch issue at cycle T: FSM -> WAIT, counter loaded with MEM_LAT-1; count 0 -> capture mem_rdata at end of cycle T+MEM_LAT-... held in WAIT until counter=0; mem_rdata sampled at end of cycle T+MEM_LAT; FSM -> RESP.
REQ-027 RESP lasts one cycle (T+MEM_LAT+1): matching rvalid/d_done pulses; if_rdata = word select ? data[63:32] : data[31:0].
REQ-028 A new issue is allowed in the RESP cycle (back-to-back reads, one issue every MEM_LAT+1 cycles).
REQ-029 Store issue at cycle T: mem_we=1, FSM stays in/returns to IDLE, d_done=1 at T+1; store issues back-to-back every cycle.
REQ-030 No grant in WAIT; reqs are ignored until IDLE or RESP.
REQ-031 If_rdata/d_rdata hold last captured value between pulses.
REQ-032 if_rvalid and d_done never both high in the same cycle; at most one access outstanding.
REQ-033 Req deasserted before gnt is legal; no access issued for it.

Reset
REQ-034 On reset=0: FSM=IDLE, counter=0, prio=fetch, if_rdata=0, d_rdata=0, all pulses and mem_en/mem_we=0.
REQ-035 Reset during WAIT discards the outstanding read; no rvalid/d_done after release.
REQ-036 First grant possible in the first clock edge after reset=1.

Verification
REQ-037 MEM_LAT=2, if_req alone, if_addr=0x104, mem word 0x20 = 0xAAAA_BBBB_1111_2222 -> if_gnt at T, mem_addr=0x100, if_rvalid at T+3, if_rdata=0xAAAA_BBBB.
REQ-038 Both reqs at T from reset (load d_addr=0x40) -> if_gnt at T, d_gnt at T+3 (RESP cycle), d_done at T+6.
REQ-039 d_req store, d_we=1, d_addr=0x18, d_wdata=0x1234 held 3 cycles -> mem_we pulses at T, T+1, T+2, d_done at T+1..T+3, mem_addr=0x18.
REQ-040 Reset asserted in WAIT after fetch issue -> all outputs 0 immediately, no if_rvalid ever after release.
REQ-041 Both reqs continuously, MEM_LAT=1 -> grants alternate fetch, data, fetch, each 2 cycles apart.
REQ-042 if_req pulsed one cycle during WAIT then dropped -> no if_gnt, no extra mem_en.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one 64-bit memory port.
// Latency: grant is combinational in the issue cycle; reads respond MEM_LAT+1 cycles after issue, stores complete one cycle after issue.
// Backpressure: requesters hold req until gnt; no grant while a read is outstanding (WAIT), so at most one read is in flight.
module mem_port_arbiter #(
    // Read latency from issue to valid mem_rdata_i, legal range 1..7
    parameter int unsigned MEM_LAT = 2
) (
    input  logic        clk_i,
    input  logic        reset_ni,

    // instruction-fetch port
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,

    // data port
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [63:0] d_addr_i,
    input  logic [63:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_done_o,
    output logic [63:0] d_rdata_o,

    // memory port
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [63:0] mem_addr_o,
    output logic [63:0] mem_wdata_o,
    input  logic [63:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Counter is loaded with MEM_LAT-1 so it hits zero in the cycle mem_rdata_i is valid
    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    // prio_q: 0 = fetch wins a tie, 1 = data wins a tie
    // owner_q: 0 = outstanding read belongs to fetch, 1 = to data
    state_t      state_q;
    logic [2:0]  cnt_q;
    logic        prio_q;
    logic        owner_q;
    logic        wsel_q;
    logic        if_rvalid_q;
    logic        d_done_q;
    logic [31:0] if_rdata_q;
    logic [63:0] d_rdata_q;

    logic        can_issue;
    logic        if_gnt;
    logic        d_gnt;

    // Byte-offset bits are don't-care on both ports
    logic        unused_addr_bits;
    assign unused_addr_bits = ^{if_addr_i[1:0], d_addr_i[2:0]};

    // Grant decision: only in IDLE/RESP and never while reset is asserted
    always_comb begin
        can_issue = reset_ni && ((state_q == ST_IDLE) || (state_q == ST_RESP));
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        if (can_issue) begin
            if (if_req_i && d_req_i) begin
                if (prio_q) begin
                    d_gnt = 1'b1;
                end else begin
                    if_gnt = 1'b1;
                end
            end else if (if_req_i) begin
                if_gnt = 1'b1;
            end else if (d_req_i) begin
                d_gnt = 1'b1;
            end
        end
    end

    // Memory port drive: address aligned to a doubleword, write data only with a data grant
    always_comb begin
        mem_addr_o  = 64'd0;
        mem_wdata_o = 64'd0;
        if (if_gnt) begin
            mem_addr_o = {32'd0, if_addr_i[31:3], 3'b000};
        end else if (d_gnt) begin
            mem_addr_o  = {d_addr_i[63:3], 3'b000};
            mem_wdata_o = d_wdata_i;
        end
    end

    assign if_gnt_o    = if_gnt;
    assign d_gnt_o     = d_gnt;
    assign mem_en_o    = if_gnt | d_gnt;
    assign mem_we_o    = d_gnt & d_we_i;

    assign if_rvalid_o = if_rvalid_q;
    assign d_done_o    = d_done_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_rdata_o   = d_rdata_q;

    // Control FSM: tracks the single outstanding read, priority, and registered response pulses
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            prio_q      <= 1'b0;
            owner_q     <= 1'b0;
            wsel_q      <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_done_q    <= 1'b0;
            if_rdata_q  <= 32'd0;
            d_rdata_q   <= 64'd0;
        end else begin
            // Response strobes are single-cycle unless re-armed below
            if_rvalid_q <= 1'b0;
            d_done_q    <= 1'b0;
            case (state_q)
                ST_WAIT: begin
                    if (cnt_q == 3'd0) begin
                        // mem_rdata_i is valid this cycle; capture into the owner's holding register
                        if (owner_q) begin
                            d_rdata_q <= mem_rdata_i;
                            d_done_q  <= 1'b1;
                        end else begin
                            if_rdata_q  <= wsel_q ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
                            if_rvalid_q <= 1'b1;
                        end
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: begin
                    // IDLE and RESP both accept a new issue
                    if (if_gnt) begin
                        state_q <= ST_WAIT;
                        cnt_q   <= LAT_M1;
                        owner_q <= 1'b0;
                        wsel_q  <= if_addr_i[2];
                        prio_q  <= 1'b1;
                    end else if (d_gnt) begin
                        prio_q <= 1'b0;
                        if (d_we_i) begin
                            // Stores are fire-and-forget: acknowledge next cycle, stay free
                            state_q  <= ST_IDLE;
                            d_done_q <= 1'b1;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= LAT_M1;
                            owner_q <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;

    // MEM_LAT=2 instance outputs
    logic        if_gnt, if_rvalid, d_gnt, d_done, mem_en, mem_we;
    logic [31:0] if_rdata;
    logic [63:0] d_rdata, mem_addr, mem_wdata, mem_rdata;

    // MEM_LAT=1 instance outputs
    logic        if_gnt1, if_rvalid1, d_gnt1, d_done1, mem_en1, mem_we1;
    logic [31:0] if_rdata1;
    logic [63:0] d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

    int total = 0;
    int bad   = 0;

    logic [63:0] pipe2_a, pipe2_b, pipe1_a;
    logic [6:0]  exp_ig, exp_dg, exp_rv, exp_dd;

    mem_port_arbiter #(.MEM_LAT(2)) u2 (
        .clk_i(clk), .reset_ni(reset_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_gnt_o(d_gnt), .d_done_o(d_done), .d_rdata_o(d_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    mem_port_arbiter #(.MEM_LAT(1)) u1 (
        .clk_i(clk), .reset_ni(reset_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt1),
        .if_rvalid_o(if_rvalid1), .if_rdata_o(if_rdata1),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_gnt_o(d_gnt1), .d_done_o(d_done1), .d_rdata_o(d_rdata1),
        .mem_en_o(mem_en1), .mem_we_o(mem_we1), .mem_addr_o(mem_addr1),
        .mem_wdata_o(mem_wdata1), .mem_rdata_i(mem_rdata1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents, by byte address of the doubleword
    function automatic logic [63:0] mem_word(input logic [63:0] a);
        case (a)
            64'h100: return 64'hAAAA_BBBB_1111_2222;
            64'h040: return 64'hDEAD_BEEF_0BAD_F00D;
            default: return 64'h0;
        endcase
    endfunction

    // Memory read pipelines: data is only present in the cycle it is due
    always @(posedge clk) begin
        pipe2_a <= (mem_en && !mem_we) ? mem_word(mem_addr) : 64'h0;
        pipe2_b <= pipe2_a;
        pipe1_a <= (mem_en1 && !mem_we1) ? mem_word(mem_addr1) : 64'h0;
    end
    assign mem_rdata  = pipe2_b;
    assign mem_rdata1 = pipe1_a;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        if_req  = 1'b0;
        if_addr = 32'h0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 64'h0;
        d_wdata = 64'h0;
        exp_ig  = 7'b0010001;
        exp_dg  = 7'b1000100;
        exp_rv  = 7'b1000100;
        exp_dd  = 7'b0010000;

        // Reset state, with a request pending that must not be granted
        repeat (2) @(posedge clk);
        #1;
        if_req  = 1'b1;
        if_addr = 32'h104;
        @(negedge clk);
        chk("rst_if_gnt", {63'd0, if_gnt}, 64'd0);
        chk("rst_mem_en", {63'd0, mem_en}, 64'd0);
        chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_if_rvalid", {63'd0, if_rvalid}, 64'd0);
        chk("rst_d_done", {63'd0, d_done}, 64'd0);
        chk("rst_if_rdata", {32'd0, if_rdata}, 64'd0);
        chk("rst_d_rdata", d_rdata, 64'd0);
        chk("rst_mem_en1", {63'd0, mem_en1}, 64'd0);

        // Single fetch at 0x104, latency 2; grant in first cycle after release
        cyc();
        reset_n = 1'b1;
        @(negedge clk);
        chk("A_T_if_gnt", {63'd0, if_gnt}, 64'd1);
        chk("A_T_mem_en", {63'd0, mem_en}, 64'd1);
        chk("A_T_mem_addr", mem_addr, 64'h100);
        chk("A_T_mem_we", {63'd0, mem_we}, 64'd0);
        chk("A_T_d_gnt", {63'd0, d_gnt}, 64'd0);
        // if_req stays high one more cycle (a pulse during WAIT) then drops
        cyc();
        @(negedge clk);
        chk("A_T1_if_gnt", {63'd0, if_gnt}, 64'd0);
        chk("A_T1_mem_en", {63'd0, mem_en}, 64'd0);
        cyc();
        if_req = 1'b0;
        @(negedge clk);
        chk("A_T2_mem_en", {63'd0, mem_en}, 64'd0);
        chk("A_T2_if_rvalid", {63'd0, if_rvalid}, 64'd0);
        cyc();
        @(negedge clk);
        chk("A_T3_if_rvalid", {63'd0, if_rvalid}, 64'd1);
        chk("A_T3_if_rdata", {32'd0, if_rdata}, 64'hAAAA_BBBB);
        chk("A_T3_d_done", {63'd0, d_done}, 64'd0);
        chk("A_T3_mem_en", {63'd0, mem_en}, 64'd0);
        cyc();
        @(negedge clk);
        chk("A_T4_if_rvalid", {63'd0, if_rvalid}, 64'd0);
        chk("A_T4_if_rdata_hold", {32'd0, if_rdata}, 64'hAAAA_BBBB);
        chk("A_T4_mem_en", {63'd0, mem_en}, 64'd0);

        // Both requesters from reset: fetch wins, load issues in the RESP cycle
        cyc();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        if_req  = 1'b1;
        if_addr = 32'h100;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 64'h40;
        @(negedge clk);
        chk("B_T_if_gnt", {63'd0, if_gnt}, 64'd1);
        chk("B_T_d_gnt", {63'd0, d_gnt}, 64'd0);
        chk("B_T_mem_addr", mem_addr, 64'h100);
        cyc();
        if_req = 1'b0;
        @(negedge clk);
        chk("B_T1_d_gnt", {63'd0, d_gnt}, 64'd0);
        cyc();
        @(negedge clk);
        chk("B_T2_d_gnt", {63'd0, d_gnt}, 64'd0);
        cyc();
        @(negedge clk);
        chk("B_T3_if_rvalid", {63'd0, if_rvalid}, 64'd1);
        chk("B_T3_if_rdata", {32'd0, if_rdata}, 64'h1111_2222);
        chk("B_T3_d_gnt", {63'd0, d_gnt}, 64'd1);
        chk("B_T3_mem_addr", mem_addr, 64'h40);
        chk("B_T3_mem_we", {63'd0, mem_we}, 64'd0);
        cyc();
        d_req = 1'b0;
        @(negedge clk);
        chk("B_T4_d_done", {63'd0, d_done}, 64'd0);
        cyc();
        @(negedge clk);
        chk("B_T5_d_done", {63'd0, d_done}, 64'd0);
        cyc();
        @(negedge clk);
        chk("B_T6_d_done", {63'd0, d_done}, 64'd1);
        chk("B_T6_d_rdata", d_rdata, 64'hDEAD_BEEF_0BAD_F00D);
        chk("B_T6_if_rvalid", {63'd0, if_rvalid}, 64'd0);
        cyc();
        @(negedge clk);
        chk("B_T7_d_done", {63'd0, d_done}, 64'd0);
        chk("B_T7_d_rdata_hold", d_rdata, 64'hDEAD_BEEF_0BAD_F00D);

        // Back-to-back stores, byte offset bits ignored
        cyc();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 64'h1B;
        d_wdata = 64'h1234;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) cyc();
            @(negedge clk);
            chk("C_d_gnt", {63'd0, d_gnt}, 64'd1);
            chk("C_mem_we", {63'd0, mem_we}, 64'd1);
            chk("C_mem_addr", mem_addr, 64'h18);
            chk("C_mem_wdata", mem_wdata, 64'h1234);
            chk("C_d_done", {63'd0, d_done}, (i > 0) ? 64'd1 : 64'd0);
        end
        cyc();
        d_req = 1'b0;
        d_we  = 1'b0;
        @(negedge clk);
        chk("C_last_d_done", {63'd0, d_done}, 64'd1);
        chk("C_idle_mem_en", {63'd0, mem_en}, 64'd0);
        chk("C_idle_mem_wdata", mem_wdata, 64'd0);
        cyc();
        @(negedge clk);
        chk("C_after_d_done", {63'd0, d_done}, 64'd0);

        // Reset during WAIT discards the outstanding fetch
        cyc();
        if_req  = 1'b1;
        if_addr = 32'h104;
        @(negedge clk);
        chk("D_if_gnt", {63'd0, if_gnt}, 64'd1);
        cyc();
        #1;
        reset_n = 1'b0;
        #1;
        chk("D_rst_if_gnt", {63'd0, if_gnt}, 64'd0);
        chk("D_rst_mem_en", {63'd0, mem_en}, 64'd0);
        chk("D_rst_mem_addr", mem_addr, 64'd0);
        chk("D_rst_if_rdata", {32'd0, if_rdata}, 64'd0);
        chk("D_rst_d_rdata", d_rdata, 64'd0);
        chk("D_rst_if_rvalid", {63'd0, if_rvalid}, 64'd0);
        cyc();
        reset_n = 1'b1;
        if_req  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("D_no_if_rvalid", {63'd0, if_rvalid}, 64'd0);
            chk("D_no_mem_en", {63'd0, mem_en}, 64'd0);
            cyc();
        end

        // MEM_LAT=1 with both requesters held: grants alternate every 2 cycles
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        if_req  = 1'b1;
        if_addr = 32'h104;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 64'h40;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) cyc();
            @(negedge clk);
            chk("E_if_gnt", {63'd0, if_gnt1}, {63'd0, exp_ig[i]});
            chk("E_d_gnt", {63'd0, d_gnt1}, {63'd0, exp_dg[i]});
            chk("E_if_rvalid", {63'd0, if_rvalid1}, {63'd0, exp_rv[i]});
            chk("E_d_done", {63'd0, d_done1}, {63'd0, exp_dd[i]});
        end
        chk("E_if_rdata", {32'd0, if_rdata1}, 64'hAAAA_BBBB);
        chk("E_d_rdata", d_rdata1, 64'hDEAD_BEEF_0BAD_F00D);
        cyc();
        if_req = 1'b0;
        d_req  = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
